// File: rtl/clock_set_if.sv
// ---------------------------------------------------------------------------
// clock_set_if
// Bundles the button inputs, the enable and the time/mode outputs of the
// clock sequencer so the controller and its environment share one port.
//   slave  : controller side (consumes ena/buttons, drives time and status)
//   master : environment side (drives ena/buttons, observes time and status)
// Signals:
//   ena        design enable
//   btn_mode   raw mode button, active-high, asynchronous
//   btn_inc    raw increment button, active-high, asynchronous
//   hours      0..23
//   minutes    0..59
//   seconds    0..59
//   mode_state 0=RUN 1=SET_HR 2=SET_MIN 3=SET_SEC
//   tick_1hz   one-cycle pulse when seconds advance in RUN
//   blank_hi   display blank request for the field being set
// ---------------------------------------------------------------------------
interface clock_set_if;
  logic       ena;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode_state;
  logic       tick_1hz;
  logic       blank_hi;

  modport slave (
    input  ena, btn_mode, btn_inc,
    output hours, minutes, seconds, mode_state, tick_1hz, blank_hi
  );

  modport master (
    output ena, btn_mode, btn_inc,
    input  hours, minutes, seconds, mode_state, tick_1hz, blank_hi
  );
endinterface

// File: rtl/clock_set_controller.sv
// ---------------------------------------------------------------------------
// clock_set_controller
// Sequencer for the simple-clock datapath: 1 Hz prescaler, HH:MM:SS counters
// with carry, and the mode FSM that sets time from two push-buttons.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    clock_set_if.slave (ena, btn_mode, btn_inc in; time, mode_state,
//          tick_1hz, blank_hi out)
// Parameters:
//   TICK_DIV      clk cycles per second
//   DEBOUNCE_CYC  stable synchronized samples needed to accept a button level
// Optional feature macro: CLOCK_CTRL_BLINK_EN (2 Hz blink on blank_hi in the
// SET states). Without it blank_hi is tied low.
// ---------------------------------------------------------------------------
module clock_set_controller #(
  parameter int TICK_DIV     = 10000000,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  clock_set_if.slave  bus
);

  localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam int             CW         = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0]  DEB_LAST   = CW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_SET_SEC = 2'd3
  } state_e;

  // Bit 0 = mode button, bit 1 = inc button.
  logic [1:0]    w_btn_raw;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_acc;
  logic [1:0]    r_press;
  logic [CW-1:0] r_cnt [2];

  state_e        r_state;
  state_e        w_state_nxt;
  logic [4:0]    r_hours;
  logic [4:0]    w_hours_nxt;
  logic [5:0]    r_minutes;
  logic [5:0]    w_minutes_nxt;
  logic [5:0]    r_seconds;
  logic [5:0]    w_seconds_nxt;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic          r_tick;
  logic          w_tick_nxt;
  logic          w_mode_p;
  logic          w_inc_p;

  assign w_btn_raw = {bus.btn_inc, bus.btn_mode};
  assign w_mode_p  = r_press[0];
  assign w_inc_p   = r_press[1];

  // Synchronizers and debouncers; these keep running while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_acc   <= 2'b00;
      r_press <= 2'b00;
      for (int i = 0; i < 2; i++) r_cnt[i] <= {CW{1'b0}};
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_acc[i]) begin
          // The last mismatching sample accepts the new level; a press is
          // emitted only for a rising accepted level.
          if (r_cnt[i] == DEB_LAST) begin
            r_acc[i]   <= r_sync2[i];
            r_press[i] <= r_sync2[i];
            r_cnt[i]   <= {CW{1'b0}};
          end else begin
            r_press[i] <= 1'b0;
            r_cnt[i]   <= r_cnt[i] + CW'(1'b1);
          end
        end else begin
          r_press[i] <= 1'b0;
          r_cnt[i]   <= {CW{1'b0}};
        end
      end
    end
  end

  // Next-state, time arithmetic and prescaler; press pulses with ena low
  // fall through the hold path and are lost.
  always_comb begin
    w_state_nxt   = r_state;
    w_hours_nxt   = r_hours;
    w_minutes_nxt = r_minutes;
    w_seconds_nxt = r_seconds;
    w_presc_nxt   = r_presc;
    w_tick_nxt    = 1'b0;
    if (bus.ena) begin
      case (r_state)
        ST_RUN: begin
          if (w_mode_p) begin
            w_state_nxt = ST_SET_HR;
            w_presc_nxt = {PW{1'b0}};
          end else if (r_presc == PRESC_LAST) begin
            w_presc_nxt = {PW{1'b0}};
            w_tick_nxt  = 1'b1;
            if (r_seconds == 6'd59) begin
              w_seconds_nxt = 6'd0;
              if (r_minutes == 6'd59) begin
                w_minutes_nxt = 6'd0;
                w_hours_nxt   = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
              end else begin
                w_minutes_nxt = r_minutes + 6'd1;
              end
            end else begin
              w_seconds_nxt = r_seconds + 6'd1;
            end
          end else begin
            w_presc_nxt = r_presc + PW'(1'b1);
          end
        end
        ST_SET_HR: begin
          w_presc_nxt = {PW{1'b0}};
          if (w_mode_p) begin
            w_state_nxt = ST_SET_MIN;
          end else if (w_inc_p) begin
            w_hours_nxt = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
          end else begin
            w_state_nxt = ST_SET_HR;
          end
        end
        ST_SET_MIN: begin
          w_presc_nxt = {PW{1'b0}};
          if (w_mode_p) begin
            w_state_nxt = ST_SET_SEC;
          end else if (w_inc_p) begin
            w_minutes_nxt = (r_minutes == 6'd59) ? 6'd0 : r_minutes + 6'd1;
          end else begin
            w_state_nxt = ST_SET_MIN;
          end
        end
        ST_SET_SEC: begin
          // Prescaler is already 0 here, so RUN starts a full second.
          w_presc_nxt = {PW{1'b0}};
          if (w_mode_p) begin
            w_state_nxt = ST_RUN;
          end else if (w_inc_p) begin
            w_seconds_nxt = 6'd0;
          end else begin
            w_state_nxt = ST_SET_SEC;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_presc_nxt = {PW{1'b0}};
        end
      endcase
    end else begin
      w_presc_nxt = r_presc;
    end
  end

  // State, time, prescaler and tick registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_hours   <= 5'd0;
      r_minutes <= 6'd0;
      r_seconds <= 6'd0;
      r_presc   <= {PW{1'b0}};
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hours   <= w_hours_nxt;
      r_minutes <= w_minutes_nxt;
      r_seconds <= w_seconds_nxt;
      r_presc   <= w_presc_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  assign bus.hours      = r_hours;
  assign bus.minutes    = r_minutes;
  assign bus.seconds    = r_seconds;
  assign bus.mode_state = r_state;
  assign bus.tick_1hz   = r_tick;

`ifdef CLOCK_CTRL_BLINK_EN
  localparam int            HALF       = (TICK_DIV / 2 > 1) ? TICK_DIV / 2 : 1;
  localparam int            BW         = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);

  logic [BW-1:0] r_blink_cnt;
  logic          r_blank;

  // Half-second blink toggle, restarted on every mode change, idle in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= {BW{1'b0}};
      r_blank     <= 1'b0;
    end else if (bus.ena) begin
      if ((w_state_nxt != r_state) || (r_state == ST_RUN)) begin
        r_blink_cnt <= {BW{1'b0}};
        r_blank     <= 1'b0;
      end else if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= {BW{1'b0}};
        r_blank     <= ~r_blank;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1'b1);
      end
    end
  end

  assign bus.blank_hi = r_blank;
`else
  assign bus.blank_hi = 1'b0;
`endif

endmodule

// File: tb/tb_clock_set_controller.sv
module tb_clock_set_controller;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   set_tick_bad;

  clock_set_if bus_if ();

  clock_set_controller #(
    .TICK_DIV     (4),
    .DEBOUNCE_CYC (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {OP_RESET, OP_MODE, OP_INC, OP_BOTH} op_e;
  typedef struct {
    op_e op;
    int  n;
    int  h;
    int  m;
    int  s;   // -1: seconds not checked (clock was running before the row)
    int  st;
  } vec_t;

  vec_t vecs [23];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // tick_1hz must never appear while a SET state is shown.
  always @(negedge clk) begin
    if (rst_n && bus_if.tick_1hz && (bus_if.mode_state != 2'd0)) set_tick_bad++;
  end

  task automatic reset_dut();
    rst_n = 1'b0;
    bus_if.ena = 1'b1;
    bus_if.btn_mode = 1'b0;
    bus_if.btn_inc = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic press(input logic do_mode, input logic do_inc);
    @(posedge clk);
    #1;
    bus_if.btn_mode = do_mode;
    bus_if.btn_inc  = do_inc;
    repeat (6) @(posedge clk);
    #1;
    bus_if.btn_mode = 1'b0;
    bus_if.btn_inc  = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic wait_mode(input int target, input int limit);
    int k;
    k = 0;
    @(negedge clk);
    while ((int'(bus_if.mode_state) != target) && (k < limit)) begin
      @(negedge clk);
      k++;
    end
    chk("wait_mode", int'(bus_if.mode_state), target);
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      case (vecs[i].op)
        OP_RESET: reset_dut();
        OP_MODE:  press(1'b1, 1'b0);
        OP_INC:   for (int k = 0; k < vecs[i].n; k++) press(1'b0, 1'b1);
        OP_BOTH:  press(1'b1, 1'b1);
        default:  ;
      endcase
      @(negedge clk);
      chk($sformatf("v%0d_state", i), int'(bus_if.mode_state), vecs[i].st);
      chk($sformatf("v%0d_hours", i), int'(bus_if.hours), vecs[i].h);
      chk($sformatf("v%0d_minutes", i), int'(bus_if.minutes), vecs[i].m);
      if (vecs[i].s >= 0) chk($sformatf("v%0d_seconds", i), int'(bus_if.seconds), vecs[i].s);
`ifndef CLOCK_CTRL_BLINK_EN
      chk($sformatf("v%0d_blank", i), int'(bus_if.blank_hi), 0);
`endif
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    total = 0;
    bad = 0;
    set_tick_bad = 0;

    // Preload to 23:59:00 through the set sequence.
    vecs[0]  = '{OP_RESET, 0,  0,  0,  0, 0};
    vecs[1]  = '{OP_MODE,  1,  0,  0, -1, 1};
    vecs[2]  = '{OP_INC,  23, 23,  0, -1, 1};
    vecs[3]  = '{OP_MODE,  1, 23,  0, -1, 2};
    vecs[4]  = '{OP_INC,  59, 23, 59, -1, 2};
    vecs[5]  = '{OP_MODE,  1, 23, 59, -1, 3};
    vecs[6]  = '{OP_INC,   1, 23, 59,  0, 3};
    // Minute wrap in SET_MIN does not carry into hours.
    vecs[7]  = '{OP_RESET, 0,  0,  0,  0, 0};
    vecs[8]  = '{OP_MODE,  1,  0,  0, -1, 1};
    vecs[9]  = '{OP_INC,   3,  3,  0, -1, 1};
    vecs[10] = '{OP_MODE,  1,  3,  0, -1, 2};
    vecs[11] = '{OP_INC,  59,  3, 59, -1, 2};
    vecs[12] = '{OP_INC,   1,  3,  0, -1, 2};
    vecs[13] = '{OP_INC,   1,  3,  1, -1, 2};
    vecs[14] = '{OP_MODE,  1,  3,  1, -1, 3};
    vecs[15] = '{OP_INC,   1,  3,  1,  0, 3};
    vecs[16] = '{OP_INC,   2,  3,  1,  0, 3};
    // Hour wrap in SET_HR, then simultaneous mode+inc at hours=5.
    vecs[17] = '{OP_RESET, 0,  0,  0,  0, 0};
    vecs[18] = '{OP_MODE,  1,  0,  0, -1, 1};
    vecs[19] = '{OP_INC,  25,  1,  0, -1, 1};
    vecs[20] = '{OP_INC,   4,  5,  0, -1, 1};
    vecs[21] = '{OP_BOTH,  1,  5,  0, -1, 2};
    vecs[22] = '{OP_INC,   1,  5,  1, -1, 2};

    // Reset state, then 240 running cycles.
    rst_n = 1'b0;
    bus_if.ena = 1'b1;
    bus_if.btn_mode = 1'b0;
    bus_if.btn_inc = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hours", int'(bus_if.hours), 0);
    chk("rst_minutes", int'(bus_if.minutes), 0);
    chk("rst_seconds", int'(bus_if.seconds), 0);
    chk("rst_mode", int'(bus_if.mode_state), 0);
    chk("rst_tick", int'(bus_if.tick_1hz), 0);
    chk("rst_blank", int'(bus_if.blank_hi), 0);
    rst_n = 1'b1;
    ticks = 0;
    repeat (240) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_if.tick_1hz) ticks++;
    end
    chk("run240_ticks", ticks, 60);
    chk("run240_hours", int'(bus_if.hours), 0);
    chk("run240_minutes", int'(bus_if.minutes), 1);
    chk("run240_seconds", int'(bus_if.seconds), 0);
    chk("run240_mode", int'(bus_if.mode_state), 0);
    chk("run240_tick", int'(bus_if.tick_1hz), 1);

    // Glitch rejection and press latency.
    reset_dut();
    @(posedge clk);
    #1 bus_if.btn_mode = 1'b1;
    @(posedge clk);
    #1 bus_if.btn_mode = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("glitch_mode", int'(bus_if.mode_state), 0);
    @(posedge clk);
    #1 bus_if.btn_mode = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k >= 4) chk($sformatf("latency_edge%0d", k), int'(bus_if.mode_state), (k == 5) ? 1 : 0);
    end
    repeat (5) @(posedge clk);
    #1 bus_if.btn_mode = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("hold_no_repeat", int'(bus_if.mode_state), 1);

    // ena low freezes time and discards presses.
    reset_dut();
    bus_if.ena = 1'b0;
    ticks = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_if.tick_1hz) ticks++;
    end
    chk("ena_lo_ticks", ticks, 0);
    chk("ena_lo_seconds", int'(bus_if.seconds), 0);
    press(1'b1, 1'b0);
    bus_if.ena = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ena_lo_press_mode", int'(bus_if.mode_state), 0);
    chk("ena_lo_press_seconds", int'(bus_if.seconds), 0);

    // Preload then midnight rollover.
    apply_range(0, 6);
    @(posedge clk);
    #1 bus_if.btn_mode = 1'b1;
    wait_mode(0, 20);
    bus_if.btn_mode = 1'b0;
    chk("exit_hours", int'(bus_if.hours), 23);
    chk("exit_minutes", int'(bus_if.minutes), 59);
    chk("exit_seconds", int'(bus_if.seconds), 0);
    repeat (235) @(posedge clk);
    @(negedge clk);
    chk("pre59_seconds", int'(bus_if.seconds), 58);
    chk("pre59_tick", int'(bus_if.tick_1hz), 0);
    @(posedge clk);
    @(negedge clk);
    chk("at59_hours", int'(bus_if.hours), 23);
    chk("at59_minutes", int'(bus_if.minutes), 59);
    chk("at59_seconds", int'(bus_if.seconds), 59);
    chk("at59_tick", int'(bus_if.tick_1hz), 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("midnight_hours", int'(bus_if.hours), 0);
    chk("midnight_minutes", int'(bus_if.minutes), 0);
    chk("midnight_seconds", int'(bus_if.seconds), 0);
    chk("midnight_tick", int'(bus_if.tick_1hz), 1);

    apply_range(7, 22);

    // Async reset in the middle of SET_MIN.
    reset_dut();
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    for (int k = 0; k < 7; k++) press(1'b0, 1'b1);
    @(negedge clk);
    chk("pre_rst_mode", int'(bus_if.mode_state), 2);
    chk("pre_rst_hours", int'(bus_if.hours), 2);
    chk("pre_rst_minutes", int'(bus_if.minutes), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_hours", int'(bus_if.hours), 0);
    chk("async_rst_minutes", int'(bus_if.minutes), 0);
    chk("async_rst_seconds", int'(bus_if.seconds), 0);
    chk("async_rst_mode", int'(bus_if.mode_state), 0);
    chk("async_rst_tick", int'(bus_if.tick_1hz), 0);
    chk("async_rst_blank", int'(bus_if.blank_hi), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_rst_mode", int'(bus_if.mode_state), 0);
    chk("post_rst_minutes", int'(bus_if.minutes), 0);

    chk("no_tick_in_set", set_tick_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
